// File: rtl/mul_seq.sv
// mul_seq -- sequential 8x8 shift-and-add multiplier driving an external ALU.
//
// The multiplier owns no adder or shifter; every arithmetic step is issued to
// a combinational ALU through alu_rd/alu_rs/alu_ctrl, and the ALU's answer
// comes back on alu_out in the same cycle. The result is kept modulo 256.
//
// Ports
//   clock      in   single clock, rising edge
//   reset_n    in   synchronous active-low reset
//   start      in   multiply request, sampled only while idle
//   op_a       in   [7:0] multiplicand, captured on start acceptance
//   op_b       in   [7:0] multiplier, captured on start acceptance
//   busy       out  high whenever the FSM is not idle
//   done       out  one-cycle pulse while in the DONE state
//   product    out  [7:0] registered result, held until the next DONE
//   alu_rd     out  [7:0] ALU first operand
//   alu_rs     out  [7:0] ALU second operand
//   alu_ctrl   out  [3:0] ALU op code (ADD=0000, SHL=0100, SHR=0101)
//   alu_out    in   [7:0] combinational ALU result for this cycle's request
//   state_dbg  out  [2:0] current FSM state encoding, for observation only
//
// Handshake: a request is a single-cycle start=1 while busy=0; it is taken on
// that rising edge. There is no backpressure on the result: done pulses for
// one cycle and product stays valid from then until the next completion.

module mul_seq #(
  parameter logic [3:0] NOP_CTRL = 4'b1000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product,
  output logic [7:0] alu_rd,
  output logic [7:0] alu_rs,
  output logic [3:0] alu_ctrl,
  input  logic [7:0] alu_out,
  output logic [2:0] state_dbg
);

  localparam logic [3:0] CTRL_ADD = 4'b0000;
  localparam logic [3:0] CTRL_SHL = 4'b0100;
  localparam logic [3:0] CTRL_SHR = 4'b0101;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_SHL  = 3'd2,
    S_SHR  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] acc;
  logic [7:0] a;
  logic [7:0] b;

  assign state_dbg = state;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      acc     <= 8'd0;
      a       <= 8'd0;
      b       <= 8'd0;
      product <= 8'd0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a    <= op_a;
            b    <= op_b;
            acc  <= 8'd0;
            busy <= 1'b1;
            if (op_b == 8'd0) begin
              // Nothing to accumulate: finish straight away with a zero result.
              state   <= S_DONE;
              product <= 8'd0;
              done    <= 1'b1;
            end else if (op_b[0]) begin
              state <= S_ADD;
            end else begin
              state <= S_SHL;
            end
          end
        end
        S_ADD: begin
          acc   <= alu_out;
          state <= S_SHL;
        end
        S_SHL: begin
          a     <= alu_out;
          state <= S_SHR;
        end
        S_SHR: begin
          b <= alu_out;
          // Decide from the freshly shifted multiplier, not the stale b.
          if (alu_out == 8'd0) begin
            state   <= S_DONE;
            product <= acc;
            done    <= 1'b1;
          end else if (alu_out[0]) begin
            state <= S_ADD;
          end else begin
            state <= S_SHL;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // ALU request decode: a pure function of the state and working registers.
  always_comb begin
    alu_rd   = 8'd0;
    alu_rs   = 8'd0;
    alu_ctrl = NOP_CTRL;
    case (state)
      S_ADD: begin
        alu_rd   = acc;
        alu_rs   = a;
        alu_ctrl = CTRL_ADD;
      end
      S_SHL: begin
        alu_rd   = a;
        alu_rs   = 8'd1;
        alu_ctrl = CTRL_SHL;
      end
      S_SHR: begin
        alu_rd   = b;
        alu_rs   = 8'd1;
        alu_ctrl = CTRL_SHR;
      end
      default: begin
        alu_rd   = 8'd0;
        alu_rs   = 8'd0;
        alu_ctrl = NOP_CTRL;
      end
    endcase
  end

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq -- bench for mul_seq: models the external ALU, drives directed
// and random multiplies, and checks latency, product, ALU request trace,
// busy/done behaviour and reset.

module tb_mul_seq;

  localparam logic [3:0] NOP = 4'b1000;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       busy;
  logic       done;
  logic [7:0] product;
  logic [7:0] alu_rd;
  logic [7:0] alu_rs;
  logic [3:0] alu_ctrl;
  logic [7:0] alu_out;
  logic [2:0] state_dbg;

  int tests = 0;
  int fails = 0;

  logic [7:0]  exp_q[$];     // expected products, in issue order
  logic [19:0] trace_q[$];   // expected {ctrl, rd, rs} per busy cycle

  mul_seq #(.NOP_CTRL(NOP)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product), .alu_rd(alu_rd),
    .alu_rs(alu_rs), .alu_ctrl(alu_ctrl), .alu_out(alu_out),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- external ALU model ----------------
  always_comb begin
    alu_out = 8'd0;
    case (alu_ctrl)
      4'b0000: alu_out = alu_rd + alu_rs;
      4'b0100: alu_out = alu_rd << alu_rs;
      4'b0101: alu_out = alu_rd >> alu_rs;
      default: alu_out = 8'd0;
    endcase
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
  endtask

  function automatic int calc_latency(input logic [7:0] b);
    int n = 0;
    int p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        n = i + 1;
        p++;
      end
    end
    return 2 * n + p + 1;
  endfunction

  // Expected ALU requests: shift-and-add over the multiplier's bits, LSB first.
  task automatic build_trace(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc_m = 8'd0;
    logic [7:0] x = a;
    logic [7:0] y = b;
    trace_q.delete();
    while (y != 8'd0) begin
      if (y[0]) begin
        trace_q.push_back({4'b0000, acc_m, x});
        acc_m = acc_m + x;
      end
      trace_q.push_back({4'b0100, x, 8'd1});
      x = x << 1;
      trace_q.push_back({4'b0101, y, 8'd1});
      y = y >> 1;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_alu"}, {alu_ctrl, alu_rd, alu_rs}, {NOP, 16'd0});
  endtask

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle. junk: 0 = start low while busy,
  // 1 = start held high with 9*9 while busy, 2 = random start/operands.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int junk);
    logic [15:0] full;
    logic [7:0]  exp_p;
    logic [19:0] exp_t;
    int          lat;
    bit          got_done;
    full = 16'(a) * 16'(b);
    exp_q.push_back(full[7:0]);
    build_trace(a, b);
    lat = calc_latency(b);
    got_done = 1'b0;
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(posedge clock);
    for (int k = 1; k <= 40 && !got_done; k++) begin
      @(negedge clock);
      if (done) begin
        got_done = 1'b1;
        exp_p = exp_q.pop_front();
        check("latency", k, lat);
        check("product", product, exp_p);
        check("busy_in_done", busy, 1'b1);
        check("alu_in_done", {alu_ctrl, alu_rd, alu_rs}, {NOP, 16'd0});
        check("trace_left", trace_q.size(), 0);
        start = (junk != 0) ? 1'b1 : 1'b0;  // must be ignored in DONE
        @(negedge clock);
        check_idle_outputs("after_done");
        check("product_hold", product, exp_p);
        start = 1'b0;
      end else begin
        exp_t = (trace_q.size() != 0) ? trace_q.pop_front() : {NOP, 16'd0};
        check("alu_trace", {alu_ctrl, alu_rd, alu_rs}, exp_t);
        check("busy", busy, 1'b1);
        case (junk)
          1: begin start = 1'b1; op_a = 8'd9; op_b = 8'd9; end
          2: begin
            start = 1'($urandom_range(0, 1));
            op_a  = 8'($urandom_range(0, 255));
            op_b  = 8'($urandom_range(0, 255));
          end
          default: start = 1'b0;
        endcase
      end
    end
    check("done_timeout", got_done, 1'b1);
    start = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    op_a    = 8'd0;
    op_b    = 8'd0;
    repeat (3) @(negedge clock);
    check_idle_outputs("reset");
    check("reset_product", product, 8'd0);
    reset_n = 1'b1;
    @(negedge clock);

    run_op(8'd3, 8'd5, 0);
    run_op(8'd3, 8'd1, 0);
    run_op(8'd200, 8'd0, 0);
    run_op(8'd255, 8'd255, 0);
    run_op(8'd3, 8'd5, 1);

    // Reset in the middle of a 7*7 run, while in SHL.
    start = 1'b1;
    op_a  = 8'd7;
    op_b  = 8'd7;
    @(posedge clock);
    @(negedge clock);              // ADD
    start = 1'b0;
    @(negedge clock);              // SHL
    check("pre_reset_shl", alu_ctrl, 4'b0100);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check_idle_outputs("mid_reset");
    check("mid_reset_product", product, 8'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("no_stale_done", done, 1'b0);
    end
    run_op(8'd2, 8'd2, 0);

    // Random back-to-back traffic with random start noise while busy.
    for (int i = 0; i < 25; i++) begin
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 Parameter NOP_CTRL, default 4'b1000: ALU control code driven when no ALU operation is in flight; it decodes to the ALU default (result 0).
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 op_a  input  8  multiplicand; captured when start is accepted.
REQ-006 op_b  input  8  multiplier; captured when start is accepted.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  high for exactly one cycle, in DONE.
REQ-009 product  output  8  registered result, op_a*op_b mod 256.
REQ-010 alu_rd  output  8  ALU first operand.
REQ-011 alu_rs  output  8  ALU second operand.
REQ-012 alu_ctrl  output  4  ALU op code (ADD=0000, SHL=0100, SHR=0101).
REQ-013 alu_out  input  8  combinational ALU result for the operands and op code driven this cycle.

Function
REQ-014 Internal registers: acc[7:0], a[7:0], b[7:0], state. States: IDLE, ADD, SHL, SHR, DONE.
REQ-015 IDLE with start=1: a<=op_a, b<=op_b, acc<=0. Next state: DONE if op_b==0; else ADD if op_b[0]==1; else SHL.
REQ-016 IDLE with start=0: remain in IDLE; all registers hold.
REQ-017 ADD: drive alu_rd=acc, alu_rs=a, alu_ctrl=0000. Update acc<=alu_out. Next state: SHL.
REQ-018 SHL: drive alu_rd=a, alu_rs=8'd1, alu_ctrl=0100. Update a<=alu_out. Next state: SHR.
REQ-019 SHR: drive alu_rd=b, alu_rs=8'd1, alu_ctrl=0101. Update b<=alu_out. Next state is chosen from alu_out: DONE if 0; else ADD if bit0==1; else SHL.
REQ-020 On every transition into DONE: product<=acc (or 0 on the op_b==0 path), taking the ADD-updated value where applicable. DONE always returns to IDLE on the next cycle.
REQ-021 In IDLE and DONE: alu_rd=0, alu_rs=0, alu_ctrl=NOP_CTRL; alu_out is ignored.
REQ-022 Arithmetic is 8-bit wrap-around; carries out of ADD and bits shifted out of SHL are discarded.
REQ-023 Latency: done is asserted L cycles after the start-accept edge, with L = 2*n + p + 1. Here n = bit length of op_b (0 for op_b==0) and p = popcount(op_b).
REQ-024 start is ignored in ADD, SHL, SHR and DONE; op_a/op_b changes after acceptance have no effect.
REQ-025 product holds its value from DONE until the next transition into DONE; it is valid while done=1 and thereafter.
REQ-026 start in the cycle immediately after DONE (state IDLE) is accepted normally; back-to-back throughput = L+1 cycles.

Reset
REQ-027 reset_n=0 at a rising edge forces state=IDLE, acc=a=b=0, product=0, done=0, busy=0 and ALU outputs to IDLE values, in any state.
REQ-028 Reset has priority over start; an operation in progress is discarded with no done pulse.

Verification
REQ-029 op_a=3, op_b=5, start for 1 cycle -> state trace ADD,SHL,SHR,SHL,SHR,ADD,SHL,SHR,DONE; done at cycle 9; product=15.
REQ-030 op_a=3, op_b=1 -> ALU trace (0000,rd=0,rs=3), (0100,rd=3,rs=1), (0101,rd=1,rs=1); done at cycle 4; product=3.
REQ-031 op_a=200, op_b=0 -> done at cycle 1; product=0; no ADD/SHL/SHR cycles.
REQ-032 op_a=255, op_b=255 -> done at cycle 25; product=8'h01 (wrap).
REQ-033 start re-asserted with op_a=9, op_b=9 while busy in a 3*5 run -> ignored; product=15; busy drops after the single done pulse.
REQ-034 reset_n=0 during SHL of a 7*7 run -> next cycle: IDLE, busy=0, done=0, product=0; a following 2*2 run -> product=4.
